// File: rtl/t5_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : t5_fetch_if                                                  |
// | Description : Instruction bus between the fetch stage and the instruction  |
// |               memory. The fetch stage is the master.                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface t5_fetch_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] iadr;
    logic            istb;
    logic            iack;
    logic [31:0]     idat_i;

    modport master (output iadr, output istb, input iack, input idat_i);
    modport slave  (input iadr, input istb, output iack, output idat_i);
endinterface
`default_nettype wire

// File: rtl/t5_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : t5_fetch                                                     |
// | Description : Fetch stage for the 4-hart barrel pipeline. Holds one word   |
// |               PC per hart and gives each hart one fetch slot every 4       |
// |               cycles. Decode sees {pc, hart} on fpc plus the instruction.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module t5_fetch #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  wire logic            sclk,
    input  wire logic            srst,
    input  wire logic            sena,
    input  wire logic [3:0]      hena,
    input  wire logic            xbra,
    input  wire logic [XLEN-1:0] xtgt,
    t5_fetch_if.master           ibus,
    output logic      [XLEN-1:0] fpc,
    output logic      [31:0]     idat,
    output logic                 fvld
);

    localparam logic [XLEN-3:0] c_rst_word = RESET_PC[XLEN-1:2];
    localparam logic [XLEN-3:0] c_pc_one   = {{(XLEN-3){1'b0}}, 1'b1};

    logic [XLEN-3:0] r_pcw [4];
    logic [1:0]      r_hptr;

    logic            w_hen;
    logic            w_issue;
    logic            w_bubble;
    logic            w_adv;
    logic [XLEN-3:0] w_cur_pc;

    // Slot decode: what the current hart does this cycle.
    always_comb begin
        w_hen    = hena[r_hptr];
        w_cur_pc = r_pcw[r_hptr];
        w_issue  = sena & w_hen & ibus.iack;
        w_bubble = sena & ~w_hen;
        // A disabled hart's slot never waits on the bus, so it always moves on.
        w_adv    = sena & (ibus.iack | ~w_hen);
        ibus.iadr = {w_cur_pc, 2'b00};
        ibus.istb = sena & w_hen & ~srst;
    end

    // Round-robin slot pointer; holds during a bus wait state or a stall.
    always_ff @(posedge sclk) begin
        if (srst) begin
            r_hptr <= 2'd0;
        end else if (w_adv) begin
            r_hptr <= r_hptr + 2'd1;
        end
    end

    // Per-hart PC file. The redirect write comes last so it overrides the
    // issue increment when both target the current hart.
    always_ff @(posedge sclk) begin
        if (srst) begin
            for (int h = 0; h < 4; h++) begin
                r_pcw[h] <= c_rst_word;
            end
        end else if (sena) begin
            if (w_issue) begin
                r_pcw[r_hptr] <= w_cur_pc + c_pc_one;
            end
            if (xbra) begin
                r_pcw[xtgt[1:0]] <= xtgt[XLEN-1:2];
            end
        end
    end

    // Decode-facing output registers: real fetch, bubble, or wait state.
    always_ff @(posedge sclk) begin
        if (srst) begin
            fpc  <= {c_rst_word, 2'b00};
            idat <= NOP;
            fvld <= 1'b0;
        end else if (sena) begin
            if (w_issue) begin
                fpc  <= {w_cur_pc, r_hptr};
                idat <= ibus.idat_i;
                fvld <= 1'b1;
            end else if (w_bubble) begin
                fpc  <= {w_cur_pc, r_hptr};
                idat <= NOP;
                fvld <= 1'b0;
            end else begin
                // Bus wait state: keep the last fetch visible but mark it stale.
                fvld <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_t5_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_t5_fetch                                                  |
// | Description : Directed self-checking bench for t5_fetch.                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_t5_fetch;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic        sclk;
    logic        srst;
    logic        sena;
    logic [3:0]  hena;
    logic        xbra;
    logic [31:0] xtgt;
    logic [31:0] fpc;
    logic [31:0] idat;
    logic        fvld;

    int ntot;
    int npass;

    t5_fetch_if #(.XLEN(32)) ibus ();

    t5_fetch #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .NOP      (c_nop)
    ) dut (
        .sclk (sclk),
        .srst (srst),
        .sena (sena),
        .hena (hena),
        .xbra (xbra),
        .xtgt (xtgt),
        .ibus (ibus.master),
        .fpc  (fpc),
        .idat (idat),
        .fvld (fvld)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick;
        @(posedge sclk);
        #1;
    endtask

    task automatic test_reset;
        srst = 1'b1; sena = 1'b1; hena = 4'hF; xbra = 1'b0; xtgt = '0;
        ibus.iack = 1'b1; ibus.idat_i = 32'h1234_5678;
        #1;
        ntot++; if (ibus.istb !== 1'b0) $display("FAIL rst_istb got %b exp 0", ibus.istb); else npass++;
        tick;
        ntot++; if (fpc !== 32'h0) $display("FAIL rst_fpc got %h exp 00000000", fpc); else npass++;
        ntot++; if (idat !== c_nop) $display("FAIL rst_idat got %h exp %h", idat, c_nop); else npass++;
        ntot++; if (fvld !== 1'b0) $display("FAIL rst_fvld got %b exp 0", fvld); else npass++;
        srst = 1'b0;
    endtask

    task automatic test_stream;
        for (int k = 0; k < 8; k++) begin
            ibus.idat_i = 32'hA000_0000 + k;
            #1;
            ntot++; if (ibus.iadr !== 32'((k / 4) * 4)) $display("FAIL stream_iadr[%0d] got %h exp %h", k, ibus.iadr, 32'((k / 4) * 4)); else npass++;
            ntot++; if (ibus.istb !== 1'b1) $display("FAIL stream_istb[%0d] got %b exp 1", k, ibus.istb); else npass++;
            tick;
            ntot++; if (fpc !== 32'(k)) $display("FAIL stream_fpc[%0d] got %h exp %h", k, fpc, 32'(k)); else npass++;
            ntot++; if (idat !== 32'hA000_0000 + k) $display("FAIL stream_idat[%0d] got %h exp %h", k, idat, 32'hA000_0000 + k); else npass++;
            ntot++; if (fvld !== 1'b1) $display("FAIL stream_fvld[%0d] got %b exp 1", k, fvld); else npass++;
        end
    endtask

    task automatic test_wait;
        for (int j = 0; j < 2; j++) begin
            ibus.idat_i = 32'hB000_0000 + j;
            tick;
            ntot++; if (fpc !== 32'h8 + j) $display("FAIL wait_pre_fpc[%0d] got %h exp %h", j, fpc, 32'h8 + j); else npass++;
        end
        ibus.iack = 1'b0;
        ibus.idat_i = 32'hDEAD_BEEF;
        for (int w = 0; w < 3; w++) begin
            #1;
            ntot++; if (ibus.iadr !== 32'h8) $display("FAIL wait_iadr[%0d] got %h exp 00000008", w, ibus.iadr); else npass++;
            ntot++; if (ibus.istb !== 1'b1) $display("FAIL wait_istb[%0d] got %b exp 1", w, ibus.istb); else npass++;
            tick;
            ntot++; if (fvld !== 1'b0) $display("FAIL wait_fvld[%0d] got %b exp 0", w, fvld); else npass++;
            ntot++; if (fpc !== 32'h9) $display("FAIL wait_fpc[%0d] got %h exp 00000009", w, fpc); else npass++;
        end
        ibus.iack = 1'b1;
        ibus.idat_i = 32'hB000_0002;
        #1;
        ntot++; if (ibus.iadr !== 32'h8) $display("FAIL wait_ack_iadr got %h exp 00000008", ibus.iadr); else npass++;
        tick;
        ntot++; if (fpc !== 32'hA) $display("FAIL wait_ack_fpc got %h exp 0000000a", fpc); else npass++;
        ntot++; if (idat !== 32'hB000_0002) $display("FAIL wait_ack_idat got %h exp b0000002", idat); else npass++;
        ntot++; if (fvld !== 1'b1) $display("FAIL wait_ack_fvld got %b exp 1", fvld); else npass++;
        #1;
        ntot++; if (ibus.iadr !== 32'h8) $display("FAIL wait_h3_iadr got %h exp 00000008", ibus.iadr); else npass++;
        tick;
        ntot++; if (fpc !== 32'hB) $display("FAIL wait_h3_fpc got %h exp 0000000b", fpc); else npass++;
    endtask

    task automatic test_redirect;
        logic [31:0] exp_iadr [4];
        logic [31:0] exp_fpc  [4];
        exp_iadr = '{32'h10, 32'h100, 32'h10, 32'h10};
        exp_fpc  = '{32'h10, 32'h101, 32'h12, 32'h13};
        tick;
        ntot++; if (fpc !== 32'hC) $display("FAIL redir_h0_fpc got %h exp 0000000c", fpc); else npass++;
        xbra = 1'b1; xtgt = 32'h0000_0101;
        #1;
        ntot++; if (ibus.iadr !== 32'hC) $display("FAIL redir_slot_iadr got %h exp 0000000c", ibus.iadr); else npass++;
        tick;
        xbra = 1'b0;
        ntot++; if (fpc !== 32'hD) $display("FAIL redir_slot_fpc got %h exp 0000000d", fpc); else npass++;
        tick;
        tick;
        for (int s = 0; s < 4; s++) begin
            #1;
            ntot++; if (ibus.iadr !== exp_iadr[s]) $display("FAIL redir_iadr[%0d] got %h exp %h", s, ibus.iadr, exp_iadr[s]); else npass++;
            tick;
            ntot++; if (fpc !== exp_fpc[s]) $display("FAIL redir_fpc[%0d] got %h exp %h", s, fpc, exp_fpc[s]); else npass++;
        end
    endtask

    task automatic test_hena;
        logic [31:0] e_iadr;
        logic [31:0] e_fpc;
        logic        e_en;
        hena = 4'b0101;
        for (int k = 0; k < 8; k++) begin
            int r;
            int s;
            r = k / 4;
            s = k % 4;
            e_en = (s == 0) || (s == 2);
            case (s)
                0:       begin e_iadr = 32'h14 + 4 * r; e_fpc = 32'h14 + 4 * r; end
                1:       begin e_iadr = 32'h104;        e_fpc = 32'h105;        end
                2:       begin e_iadr = 32'h14 + 4 * r; e_fpc = 32'h16 + 4 * r; end
                default: begin e_iadr = 32'h14;         e_fpc = 32'h17;         end
            endcase
            ibus.idat_i = 32'hC000_0000 + k;
            #1;
            ntot++; if (ibus.iadr !== e_iadr) $display("FAIL hena_iadr[%0d] got %h exp %h", k, ibus.iadr, e_iadr); else npass++;
            ntot++; if (ibus.istb !== e_en) $display("FAIL hena_istb[%0d] got %b exp %b", k, ibus.istb, e_en); else npass++;
            tick;
            ntot++; if (fpc !== e_fpc) $display("FAIL hena_fpc[%0d] got %h exp %h", k, fpc, e_fpc); else npass++;
            ntot++; if (idat !== (e_en ? 32'hC000_0000 + k : c_nop)) $display("FAIL hena_idat[%0d] got %h exp %h", k, idat, (e_en ? 32'hC000_0000 + k : c_nop)); else npass++;
            ntot++; if (fvld !== e_en) $display("FAIL hena_fvld[%0d] got %b exp %b", k, fvld, e_en); else npass++;
        end
        hena = 4'hF;
    endtask

    task automatic test_stall;
        logic [31:0] exp_iadr [3];
        logic [31:0] exp_fpc  [3];
        exp_iadr = '{32'h104, 32'h1C, 32'h14};
        exp_fpc  = '{32'h105, 32'h1E, 32'h17};
        ibus.idat_i = 32'hD000_0000;
        tick;
        ntot++; if (fpc !== 32'h1C) $display("FAIL stall_pre_fpc got %h exp 0000001c", fpc); else npass++;
        sena = 1'b0; xbra = 1'b1; xtgt = 32'h0000_0201; ibus.idat_i = 32'hDEAD_0000;
        for (int c = 0; c < 5; c++) begin
            #1;
            ntot++; if (ibus.istb !== 1'b0) $display("FAIL stall_istb[%0d] got %b exp 0", c, ibus.istb); else npass++;
            tick;
            ntot++; if (fpc !== 32'h1C) $display("FAIL stall_fpc[%0d] got %h exp 0000001c", c, fpc); else npass++;
            ntot++; if (idat !== 32'hD000_0000) $display("FAIL stall_idat[%0d] got %h exp d0000000", c, idat); else npass++;
            ntot++; if (fvld !== 1'b1) $display("FAIL stall_fvld[%0d] got %b exp 1", c, fvld); else npass++;
        end
        sena = 1'b1; xbra = 1'b0;
        for (int s = 0; s < 3; s++) begin
            ibus.idat_i = 32'hD000_0001 + s;
            #1;
            ntot++; if (ibus.iadr !== exp_iadr[s]) $display("FAIL stall_resume_iadr[%0d] got %h exp %h", s, ibus.iadr, exp_iadr[s]); else npass++;
            tick;
            ntot++; if (fpc !== exp_fpc[s]) $display("FAIL stall_resume_fpc[%0d] got %h exp %h", s, fpc, exp_fpc[s]); else npass++;
        end
    endtask

    task automatic test_wrap_and_reset;
        xbra = 1'b1; xtgt = 32'hFFFF_FFFC;
        #1;
        ntot++; if (ibus.iadr !== 32'h20) $display("FAIL wrap_pre_iadr got %h exp 00000020", ibus.iadr); else npass++;
        tick;
        xbra = 1'b0;
        ntot++; if (fpc !== 32'h20) $display("FAIL wrap_pre_fpc got %h exp 00000020", fpc); else npass++;
        tick; tick; tick;
        #1;
        ntot++; if (ibus.iadr !== 32'hFFFF_FFFC) $display("FAIL wrap_top_iadr got %h exp fffffffc", ibus.iadr); else npass++;
        tick;
        ntot++; if (fpc !== 32'hFFFF_FFFC) $display("FAIL wrap_top_fpc got %h exp fffffffc", fpc); else npass++;
        tick; tick; tick;
        #1;
        ntot++; if (ibus.iadr !== 32'h0) $display("FAIL wrap_zero_iadr got %h exp 00000000", ibus.iadr); else npass++;
        tick;
        ntot++; if (fpc !== 32'h0) $display("FAIL wrap_zero_fpc got %h exp 00000000", fpc); else npass++;
        ibus.iack = 1'b0;
        tick;
        srst = 1'b1;
        #1;
        ntot++; if (ibus.istb !== 1'b0) $display("FAIL rstwait_istb got %b exp 0", ibus.istb); else npass++;
        tick;
        ntot++; if (fpc !== 32'h0) $display("FAIL rstwait_fpc got %h exp 00000000", fpc); else npass++;
        ntot++; if (idat !== c_nop) $display("FAIL rstwait_idat got %h exp %h", idat, c_nop); else npass++;
        ntot++; if (fvld !== 1'b0) $display("FAIL rstwait_fvld got %b exp 0", fvld); else npass++;
        srst = 1'b0; ibus.iack = 1'b1; ibus.idat_i = 32'hE000_0000;
        #1;
        ntot++; if (ibus.iadr !== 32'h0) $display("FAIL rstwait_h0_iadr got %h exp 00000000", ibus.iadr); else npass++;
        ntot++; if (ibus.istb !== 1'b1) $display("FAIL rstwait_h0_istb got %b exp 1", ibus.istb); else npass++;
        tick;
        ntot++; if (fpc !== 32'h0) $display("FAIL rstwait_h0_fpc got %h exp 00000000", fpc); else npass++;
        ntot++; if (idat !== 32'hE000_0000) $display("FAIL rstwait_h0_idat got %h exp e0000000", idat); else npass++;
        ntot++; if (fvld !== 1'b1) $display("FAIL rstwait_h0_fvld got %b exp 1", fvld); else npass++;
        #1;
        ntot++; if (ibus.iadr !== 32'h0) $display("FAIL rstwait_h1_iadr got %h exp 00000000", ibus.iadr); else npass++;
        tick;
        ntot++; if (fpc !== 32'h1) $display("FAIL rstwait_h1_fpc got %h exp 00000001", fpc); else npass++;
    endtask

    initial begin
        ntot  = 0;
        npass = 0;
        test_reset;
        test_stream;
        test_wait;
        test_redirect;
        test_hena;
        test_stall;
        test_wrap_and_reset;
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
`default_nettype wire
